// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the counter scheduler slice.
// State encoding is fixed at 2 bits so it can be probed directly on debug buses.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } sched_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure (valid low when req is empty).
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                        req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic                                valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
  output logic [N-1:0]                        onehot
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    ptr_w;
  logic [IW-1:0]  sel;
  logic [IW:0]    sum;
  logic [IW:0]    sum_wrap;

  always_comb begin
    dbl   = {req, req};
    ptr_w = {1'b0, ptr};
    rot   = dbl[ptr_w +: N];
    valid = |req;

    // Scan downwards so the lowest set bit of the rotated vector wins.
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sel = IW'(i);
    end

    sum      = ptr_w + {1'b0, sel};
    sum_wrap = (sum >= N_W) ? (sum - N_W) : sum;
    idx      = sum_wrap[IW-1:0];
    onehot   = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cnt_scheduler.sv
// Time-shares one external up-counter among N_REQ requesters, round-robin, len cycles each.
// Latency: grant/clr 1 cycle after req, done at len+2; owner dropping req aborts the run.
module cnt_scheduler
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_clr,
  output logic                   cnt_en,
  input  logic [CNT_W-1:0]       cnt_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t     state, state_nx;
  logic [IW-1:0]    ptr, ptr_nx;
  logic [IW-1:0]    own, own_nx;
  logic [N_REQ-1:0] grant_q, grant_nx;
  logic [CNT_W-1:0] len_l, len_l_nx;
  logic [CNT_W-1:0] len_m1;
  logic             own_req;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (v == IW'(N_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_vld),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  assign len_m1  = len_l - CNT_W'(1);
  assign own_req = req[own];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      own     <= '0;
      grant_q <= '0;
      len_l   <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      own     <= own_nx;
      grant_q <= grant_nx;
      len_l   <= len_l_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    own_nx   = own;
    grant_nx = grant_q;
    len_l_nx = len_l;

    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nx = S_CLEAR;
          own_nx   = pick_idx;
          grant_nx = pick_oh;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) len_l_nx = len[i*CNT_W +: CNT_W];
          end
        end
      end

      S_CLEAR: begin
        if (!own_req) begin
          state_nx = S_IDLE;
          grant_nx = '0;
          ptr_nx   = inc_mod(own);
        end else if (len_l == '0) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_RUN;
        end
      end

      S_RUN: begin
        // An out-of-range cnt_q also ends the run so a faulty counter cannot hang us.
        if (!own_req) begin
          state_nx = S_IDLE;
          grant_nx = '0;
          ptr_nx   = inc_mod(own);
        end else if (cnt_q >= len_m1) begin
          state_nx = S_DONE;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
        grant_nx = '0;
        ptr_nx   = inc_mod(own);
      end

      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign done    = (state == S_DONE) ? grant_q : '0;
  assign busy    = (state != S_IDLE);
  assign cnt_clr = (state == S_CLEAR);
  assign cnt_en  = (state == S_RUN);

endmodule
